// File: rtl/echo_pkg.sv
// Shared widths, ramp FSM state type and the saturating sample adder
// used by the echo mixer and its gain ramp.
package echo_pkg;

   localparam int SAMPLE_W = 16;
   localparam int GAIN_W   = 8;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      STEADY    = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_t;

   localparam logic signed [SAMPLE_W-1:0] SMAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SAMPLE_W-1:0] SMIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   // One guard bit is enough: the sum of two SAMPLE_W values never overflows SAMPLE_W+1.
   function automatic logic signed [SAMPLE_W-1:0] sat_add(
      input logic signed [SAMPLE_W-1:0] a,
      input logic signed [SAMPLE_W-1:0] b
   );
      logic signed [SAMPLE_W:0]   sum;
      logic signed [SAMPLE_W-1:0] res;
      sum = (SAMPLE_W+1)'(a) + (SAMPLE_W+1)'(b);
      if (sum > (SAMPLE_W+1)'(SMAX))
         res = SMAX;
      else if (sum < (SAMPLE_W+1)'(SMIN))
         res = SMIN;
      else
         res = sum[SAMPLE_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/echo_gain_ramp.sv
// Gain ramp FSM: walks gain_cur one LSB per sample strobe toward the
// target (gain_in when enabled, else 0) so gain changes never click.
module echo_gain_ramp
   import echo_pkg::*;
#(
   parameter int GW = GAIN_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          sample_valid,
   input  logic          enable,
   input  logic [GW-1:0] gain_in,
   output logic [GW-1:0] gain_cur,
   output logic          ramping
);

   localparam logic [GW-1:0] GMAX = '1;

   ramp_state_t   state, state_nxt, settle_st;
   logic [GW-1:0] target, gain_nxt, gain_up, gain_dn;

   assign target    = enable ? gain_in : '0;
   assign gain_up   = (gain_cur == GMAX) ? gain_cur : gain_cur + GW'(1);
   assign gain_dn   = (gain_cur == '0)   ? gain_cur : gain_cur - GW'(1);
   assign settle_st = (target == '0) ? MUTED : STEADY;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= MUTED;
         gain_cur <= '0;
      end else if (sample_valid) begin
         state    <= state_nxt;
         gain_cur <= gain_nxt;
      end
   end

   // Direction reversals hold the gain for one strobe; entries from rest step at once.
   always_comb begin
      state_nxt = state;
      gain_nxt  = gain_cur;
      case (state)
         MUTED: begin
            gain_nxt = '0;
            if (target != '0) begin
               gain_nxt  = GW'(1);
               state_nxt = (target == GW'(1)) ? STEADY : RAMP_UP;
            end
         end
         RAMP_UP: begin
            if (target < gain_cur)
               state_nxt = RAMP_DOWN;
            else if (target == gain_cur)
               state_nxt = STEADY;
            else begin
               gain_nxt = gain_up;
               if (gain_up == target)
                  state_nxt = STEADY;
            end
         end
         RAMP_DOWN: begin
            if (target > gain_cur)
               state_nxt = RAMP_UP;
            else if (target == gain_cur)
               state_nxt = settle_st;
            else begin
               gain_nxt = gain_dn;
               if (gain_dn == target)
                  state_nxt = settle_st;
            end
         end
         STEADY: begin
            if (target > gain_cur) begin
               gain_nxt  = gain_up;
               state_nxt = (gain_up == target) ? STEADY : RAMP_UP;
            end else if (target < gain_cur) begin
               gain_nxt  = gain_dn;
               state_nxt = (gain_dn == target) ? settle_st : RAMP_DOWN;
            end else if (gain_cur == '0) begin
               state_nxt = MUTED;
            end
         end
         default: state_nxt = MUTED;
      endcase
   end

   always_comb begin
      ramping = (state == RAMP_UP) || (state == RAMP_DOWN);
   end

endmodule

// File: rtl/echo_mixer.sv
// Echo mixer: wet = sat(dry + floor(dly * gain / 2^GW)) through a 3-stage
// pipeline; the same sample is returned as delay-line feedback.
module echo_mixer
   import echo_pkg::*;
#(
   parameter int DW = SAMPLE_W,
   parameter int GW = GAIN_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          sample_valid,
   input  logic [DW-1:0] dry_in,
   input  logic [DW-1:0] dly_in,
   input  logic          enable,
   input  logic [GW-1:0] gain_in,
   output logic [DW-1:0] wet_out,
   output logic [DW-1:0] fb_out,
   output logic          out_valid,
   output logic [GW-1:0] gain_cur,
   output logic          ramping
);

   localparam int PW = DW + GW + 1;

   logic                 vld_p1, vld_p2;
   logic signed [DW-1:0] dry_p1, dly_p1, dry_p2, scaled_p2;
   logic        [GW-1:0] gain_p1;
   logic signed [PW-1:0] prod;
   logic signed [DW-1:0] scaled;

   echo_gain_ramp #(.GW(GW)) u_ramp (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .enable       (enable),
      .gain_in      (gain_in),
      .gain_cur     (gain_cur),
      .ramping      (ramping)
   );

   // Stage 1: capture the sample pair with the gain in force before this strobe's ramp step
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         dry_p1  <= '0;
         dly_p1  <= '0;
         gain_p1 <= '0;
      end else begin
         vld_p1 <= sample_valid;
         if (sample_valid) begin
            dry_p1  <= $signed(dry_in);
            dly_p1  <= $signed(dly_in);
            gain_p1 <= gain_cur;
         end
      end
   end

   // Stage 2: gain is an unsigned fraction, so zero-extend before the signed multiply
   assign prod   = PW'(dly_p1) * PW'($signed({1'b0, gain_p1}));
   assign scaled = DW'(prod >>> GW);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p2    <= 1'b0;
         dry_p2    <= '0;
         scaled_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            dry_p2    <= dry_p1;
            scaled_p2 <= scaled;
         end
      end
   end

   // Stage 3: saturating mix; output holds between strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         wet_out   <= '0;
      end else begin
         out_valid <= vld_p2;
         if (vld_p2)
            wet_out <= sat_add(dry_p2, scaled_p2);
      end
   end

   assign fb_out = wet_out;

endmodule

// File: tb/tb_echo_mixer.sv
// Self-checking bench for echo_mixer: directed vectors and sequences plus a
// randomized run checked every cycle against a behavioural reference model.
module tb_echo_mixer;

   localparam int DW = 16;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          sample_valid = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] dry_in = '0;
   logic [DW-1:0] dly_in = '0;
   logic [GW-1:0] gain_in = '0;
   logic [DW-1:0] wet_out, fb_out;
   logic          out_valid;
   logic [GW-1:0] gain_cur;
   logic          ramping;

   int checks = 0;
   int passes = 0;
   bit sb_on  = 1'b0;

   echo_mixer #(.DW(DW), .GW(GW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .dry_in       (dry_in),
      .dly_in       (dly_in),
      .enable       (enable),
      .gain_in      (gain_in),
      .wet_out      (wet_out),
      .fb_out       (fb_out),
      .out_valid    (out_valid),
      .gain_cur     (gain_cur),
      .ramping      (ramping)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: floor(dly*g/256) added to dry, clamped to the 16-bit range.
   function automatic int ref_wet(int dry, int dly, int g);
      int p, q, s;
      p = dly * g;
      q = p / 256;
      if (p < 0 && (p % 256) != 0) q = q - 1;
      s = dry + q;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return s;
   endfunction

   // Reference model: pending results keyed by due cycle, gain tracked by direction.
   typedef struct {int due; int wet;} pend_t;
   pend_t pend[$];
   int    m_g = 0, m_dir = 0, m_wet = 0, cyc = 0;
   bit    m_ovld = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      int t, g, d, w;
      bit ov;
      if (!reset_n) begin
         pend.delete();
         m_g    <= 0;
         m_dir  <= 0;
         m_wet  <= 0;
         m_ovld <= 1'b0;
         cyc    <= 0;
      end else begin
         ov = 1'b0;
         w  = m_wet;
         g  = m_g;
         d  = m_dir;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            w  = pend[0].wet;
            ov = 1'b1;
            void'(pend.pop_front());
         end
         if (sample_valid) begin
            pend.push_back('{due: cyc + 2, wet: ref_wet($signed(dry_in), $signed(dly_in), m_g)});
            t = enable ? int'(gain_in) : 0;
            if (d == 1 && t < g) d = 2;
            else if (d == 2 && t > g) d = 1;
            else if (g < t) begin g = g + 1; d = (g == t) ? 0 : 1; end
            else if (g > t) begin g = g - 1; d = (g == t) ? 0 : 2; end
            else d = 0;
         end
         m_wet  <= w;
         m_ovld <= ov;
         m_g    <= g;
         m_dir  <= d;
         cyc    <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (sb_on && reset_n) begin
         check("sb_valid", out_valid, m_ovld);
         check("sb_wet", $signed(wet_out), m_wet);
         check("sb_fb", $signed(fb_out), m_wet);
         check("sb_gain", gain_cur, m_g);
         check("sb_ramping", ramping, m_dir != 0);
      end
   end

   // All tasks are entered at a falling edge and return at a falling edge.
   task automatic pulse(input int dry, input int dly);
      sample_valid = 1'b1;
      dry_in = 16'(dry);
      dly_in = 16'(dly);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic run_one(input int dry, input int dly, output int lat);
      sample_valid = 1'b1;
      dry_in = 16'(dry);
      dly_in = 16'(dly);
      lat = 0;
      do begin
         @(negedge clk);
         sample_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 8);
   endtask

   task automatic ramp_to(input bit en, input int g);
      int n, tgt;
      enable  = en;
      gain_in = 8'(g);
      tgt = en ? g : 0;
      n = 0;
      while ((int'(gain_cur) != tgt || ramping) && n < 600) begin
         pulse(0, 0);
         n++;
      end
      check("ramp_settle", gain_cur, tgt);
      repeat (4) @(negedge clk);
   endtask

   typedef struct {int gain; int dry; int dly; int wet;} vec_t;

   initial begin
      vec_t vt[12];
      int   lat;

      vt[0]  = '{128,   1000,   2000,   2000};
      vt[1]  = '{128,   -100,     -3,   -102};
      vt[2]  = '{128,      0,  32767,  16383};
      vt[3]  = '{128,  20000,  32767,  32767};
      vt[4]  = '{128, -32768, -32768, -32768};
      vt[5]  = '{255,  30000,  20000,  32767};
      vt[6]  = '{255, -30000, -20000, -32768};
      vt[7]  = '{255,    100,     -1,     99};
      vt[8]  = '{255, -32768,  32767,   -129};
      vt[9]  = '{255,  32767, -32768,    127};
      vt[10] = '{255,      0,      1,      0};
      vt[11] = '{255,     -1,    256,    254};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_wet", $signed(wet_out), 0);
      check("rst_fb", $signed(fb_out), 0);
      check("rst_valid", out_valid, 0);
      check("rst_gain", gain_cur, 0);
      check("rst_ramping", ramping, 0);
      reset_n = 1'b1;
      sb_on   = 1'b1;

      // Ramp up to 4 with a strobe every 4 cycles
      enable  = 1'b1;
      gain_in = 8'd4;
      for (int i = 1; i <= 4; i++) begin
         pulse(0, 0);
         check("ramp_up_gain", gain_cur, i);
         check("ramp_up_flag", ramping, i < 4);
         repeat (3) @(negedge clk);
      end
      repeat (2) @(negedge clk);

      // Directed vector table at steady gain
      for (int i = 0; i < 12; i++) begin
         ramp_to(1'b1, vt[i].gain);
         run_one(vt[i].dry, vt[i].dly, lat);
         check("vec_latency", lat, 3);
         check("vec_wet", $signed(wet_out), vt[i].wet);
         check("vec_fb", $signed(fb_out), vt[i].wet);
         @(negedge clk);
         check("vec_pulse_end", out_valid, 0);
         check("vec_hold", $signed(wet_out), vt[i].wet);
      end

      // Back-to-back strobes, gain 255
      ramp_to(1'b1, 255);
      for (int c = 0; c < 20; c++) begin
         if (c >= 3 && c < 19) begin
            check("b2b_valid", out_valid, 1);
            check("b2b_wet", $signed(wet_out), ref_wet(0, (c - 2) * 1999 - 16000, 255));
         end
         if (c == 19) check("b2b_end", out_valid, 0);
         sample_valid = (c < 16);
         dry_in = '0;
         dly_in = 16'((c + 1) * 1999 - 16000);
         @(negedge clk);
      end
      sample_valid = 1'b0;

      // Ramp down to mute, then mix with gain 0
      ramp_to(1'b1, 4);
      enable = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         pulse(0, 0);
         check("ramp_dn_gain", gain_cur, 4 - i);
         check("ramp_dn_flag", ramping, i < 4);
      end
      repeat (4) @(negedge clk);
      run_one(500, 1000, lat);
      check("muted_latency", lat, 3);
      check("muted_wet", $signed(wet_out), 500);

      // Reversal mid ramp-down
      repeat (2) @(negedge clk);
      ramp_to(1'b1, 4);
      enable = 1'b0;
      pulse(0, 0);
      pulse(0, 0);
      check("rev_pre_gain", gain_cur, 2);
      enable  = 1'b1;
      gain_in = 8'd6;
      pulse(0, 0);
      check("rev_hold_gain", gain_cur, 2);
      check("rev_flag", ramping, 1);
      pulse(0, 0);
      check("rev_up_gain", gain_cur, 3);

      // Reset one cycle after a strobe discards the in-flight sample
      ramp_to(1'b1, 100);
      run_one(1000, 2000, lat);
      check("pre_rst_wet", $signed(wet_out), 1781);
      repeat (2) @(negedge clk);
      sample_valid = 1'b1;
      dry_in = 16'd1234;
      dly_in = 16'd4321;
      @(negedge clk);
      sample_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check("midrst_wet", $signed(wet_out), 0);
      check("midrst_fb", $signed(fb_out), 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_gain", gain_cur, 0);
      check("midrst_ramping", ramping, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_no_valid", out_valid, 0);
      end

      // Randomized run against the reference model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 29) == 0) enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       gain_in = 8'($urandom_range(0, 6));
               1:       gain_in = 8'd255;
               2:       gain_in = 8'($urandom_range(0, 255));
               default: gain_in = gain_in + 8'($urandom_range(0, 4));
            endcase
         end
         sample_valid = ($urandom_range(0, 2) != 0);
         dry_in = 16'($urandom);
         dly_in = 16'($urandom);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
